// File: rtl/clock_defs.sv
// clock_defs: shared BCD widths, modulo limits and the BCD increment helper
package clock_defs;
  localparam int DW = 4;
  localparam logic [2*DW-1:0] SEC_MAX = 8'h59;
  localparam logic [2*DW-1:0] MIN_MAX = 8'h59;
  localparam logic [2*DW-1:0] HR_MAX  = 8'h23;
  function automatic logic [2*DW-1:0] bcd_next(input logic [2*DW-1:0] v, input logic [2*DW-1:0] max);
    return (v == max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MAX, with a second increment for coincident steps
module bcd_mod_counter
  import clock_defs::*;
#(
  parameter logic [2*DW-1:0] MAX = 8'h59
) (
  input  logic            clk,
  input  logic            RESETn,
  input  logic            inc,
  input  logic            inc2,
  input  logic            clr,
  output logic [2*DW-1:0] value,
  output logic            carry
);
  logic [2*DW-1:0] n1, n2;
  always_comb begin
    n1 = inc ? bcd_next(value, MAX) : value;
    n2 = inc2 ? bcd_next(n1, MAX) : n1;
  end
  assign carry = inc && (value == MAX);
  always_ff @(posedge clk or negedge RESETn)
    if (!RESETn) value <= '0;
    else value <= clr ? '0 : n2;
endmodule

// File: rtl/clock_bcd_core.sv
// clock_bcd_core: 1 Hz prescaler plus BCD HH:MM:SS time-of-day counter with set buttons
module clock_bcd_core
  import clock_defs::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic          clk,
  input  logic          RESETn,
  input  logic          run_en,
  input  logic          set_min,
  input  logic          set_hr,
  output logic [DW-1:0] hr_tens,
  output logic [DW-1:0] hr_ones,
  output logic [DW-1:0] min_tens,
  output logic [DW-1:0] min_ones,
  output logic [7:0]    sec_bcd,
  output logic          colon_on,
  output logic          sec_tick
);
  localparam int PW = $clog2(CLK_HZ);
  logic [PW-1:0] pre;
  logic rel, s_min, p_min, s_hr, p_hr;
  logic tick, min_edge, hr_edge, sec_carry, min_carry, unused_hr_carry;
  logic [7:0] mins, hrs;
  assign tick     = run_en && (pre == PW'(CLK_HZ - 1));
  assign min_edge = s_min & ~p_min;
  assign hr_edge  = s_hr & ~p_hr;
  assign colon_on = pre < PW'(CLK_HZ / 2);
  // until the first clock after reset, prev tracks the raw level so a held button cannot fire
  always_ff @(posedge clk or negedge RESETn)
    if (!RESETn) begin
      rel      <= 1'b0;
      s_min    <= 1'b0;
      p_min    <= 1'b0;
      s_hr     <= 1'b0;
      p_hr     <= 1'b0;
      pre      <= '0;
      sec_tick <= 1'b0;
    end else begin
      rel      <= 1'b1;
      s_min    <= set_min;
      p_min    <= rel ? s_min : set_min;
      s_hr     <= set_hr;
      p_hr     <= rel ? s_hr : set_hr;
      pre      <= (min_edge || tick) ? '0 : pre + PW'(run_en);
      sec_tick <= tick & ~min_edge;
    end
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .RESETn(RESETn), .inc(tick & ~min_edge), .inc2(1'b0), .clr(min_edge),
    .value(sec_bcd), .carry(sec_carry)
  );
  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .RESETn(RESETn), .inc(min_edge | sec_carry), .inc2(1'b0), .clr(1'b0),
    .value(mins), .carry(min_carry)
  );
  // a set_hr press coinciding with a natural hour carry advances hours by two
  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .RESETn(RESETn), .inc(hr_edge), .inc2(min_carry & ~min_edge), .clr(1'b0),
    .value(hrs), .carry(unused_hr_carry)
  );
  assign {hr_tens, hr_ones}   = hrs;
  assign {min_tens, min_ones} = mins;
endmodule

// File: doc/clock_bcd_core.md
# clock_bcd_core

Time-of-day counter that feeds the 7-segment scan/multiplex stage. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds in BCD. It presents four BCD digits (HH:MM) plus a colon-blink flag, which the display driver consumes directly in place of the DIP-switch hex inputs. Two button inputs set the time.

## Interface
- CLK_HZ, 50_000_000: system clock frequency; one second = CLK_HZ cycles (minimum 2, must be even).
- clk  in  1  system clock; all state on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- run_en  in  1  high = time advances; low = prescaler frozen (set buttons still work).
- set_min  in  1  debounced, synchronous level; each rising edge advances minutes.
- set_hr  in  1  debounced, synchronous level; each rising edge advances hours.
- hr_tens  out  4  BCD 0..2.
- hr_ones  out  4  BCD 0..9 (0..3 when hr_tens = 2).
- min_tens  out  4  BCD 0..5.
- min_ones  out  4  BCD 0..9.
- sec_bcd  out  8  {tens, ones}, BCD 00..59.
- colon_on  out  1  high during first half of each second.
- sec_tick  out  1  one-cycle pulse when seconds advance.

## Operation
- Prescaler `pre` counts 0..CLK_HZ-1 while run_en = 1, then wraps to 0.
  - tick = (pre == CLK_HZ-1) && run_en.
  - run_en = 0 holds `pre`.
- Seconds counter 00..59.
  - tick increments it.
  - 59 -> 00 generates minute carry.
- Minutes counter 00..59.
  - Incremented by minute carry.
  - 59 -> 00 generates hour carry.
- Hours counter 00..23; 23 -> 00 wraps with no further carry.
- All counters are native BCD.
  - Ones digit 9 -> 0 with tens +1.
  - Modulo check is on the full two-digit value.
  - Binary intermediates are never used.
- set_min rising edge (registered edge detect: prev level 0, current 1):
  - minutes = (minutes+1) mod 60, with no carry into hours;
  - seconds = 00, pre = 0;
  - a tick in the same cycle is discarded.
- set_hr rising edge:
  - hours = (hours + 1 + hour_carry) mod 24;
  - seconds, minutes and pre are unaffected; a same-cycle tick still advances them normally.
- set_min and set_hr edges in the same cycle: both actions apply, and no carry from minutes reaches hours.
- Held button (level high for any number of cycles) gives exactly one increment.
- colon_on = (pre < CLK_HZ/2).
- sec_tick = registered tick, masked in the cycle a set_min edge discards it.

## Timing
- Reset (RESETn low, asynchronous):
  - all digits 0, sec_bcd = 8'h00, pre = 0;
  - colon_on = 1, sec_tick = 0;
  - edge-detect registers = 0.
- Reset asserted mid-count clears everything immediately, without waiting for clk.
- Counting resumes on the first clk edge after RESETn rises.
- Latency:
  - all digit outputs are registered;
  - a tick at edge N shows updated digits and sec_tick = 1 after edge N.
- Button edge latency: input sampled at edge N; edge detected at edge N+1; digits update at edge N+1.
- A button already high when reset releases produces no increment, because the prev register resets to 0 and is gated by a reset-release flag.
- First tick after reset arrives at cycle CLK_HZ.
- Seconds period is exactly CLK_HZ cycles while run_en stays high.

## Structure
- Shared package/include clock_defs:
  - BCD digit width (4);
  - modulo constants SEC_MAX = 8'h59, MIN_MAX = 8'h59, HR_MAX = 8'h23.
- One natural sub-module, bcd_mod_counter:
  - two-digit BCD counter with MAX parameter;
  - ports: clk, RESETn, inc, clr, outputs value[7:0] and carry (inc && value == MAX).
  - Instantiated three times: sec, min, hr.
- Prescaler, edge detect and colon logic stay in the top.

## Test plan
All scenarios use CLK_HZ = 4.
- Reset: RESETn low 3 cycles -> digits 0/0/0/0, sec_bcd 00, colon_on 1, sec_tick 0.
- Run 240 cycles from reset -> sec_bcd 00, min_ones 1, min_tens 0, hours 00; sec_tick pulses exactly 60 times.
- Set 23:59 with buttons (23 set_hr pulses, 59 set_min pulses), then run 240 cycles -> 00:00, with the wrap from 23:59:59 occurring on a single tick.
- At 00:59 pulse set_min -> 00:00 with hours unchanged; sec_bcd 00; pre restarts (next tick after 4 cycles).
- Hold set_hr high 10 cycles -> hours +1 only. Pulse set_hr coincident with an hour carry from 12:59:59 -> 14:00:00.
- run_en low 20 cycles -> all outputs frozen, colon_on constant. RESETn low mid-second -> outputs zero before the next clk edge.
